// File: rtl/johnson_pkg.sv
// Shared widths and FSM encoding for the Johnson counter phase monitor.
package johnson_pkg;
    localparam int JC_W  = 8;
    localparam int PH_W  = 4;
    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;
endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: maps an 8-bit code to {legal, phase}.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [JC_W-1:0] jc_in,
    output logic            legal,
    output logic [PH_W-1:0] phase
);
    localparam logic [JC_W-1:0] ONES = '1;

    // Filling half: ones packed from the MSB (phases 0..8); draining half:
    // ones packed from the LSB (phases 9..15).
    always_comb begin
        legal = 1'b0;
        phase = '0;
        for (int k = 0; k <= JC_W; k++) begin
            if (jc_in == (ONES << (JC_W - k))) begin
                legal = 1'b1;
                phase = PH_W'(k);
            end
        end
        for (int k = 1; k < JC_W; k++) begin
            if (jc_in == (ONES >> (JC_W - k))) begin
                legal = 1'b1;
                phase = PH_W'(2 * JC_W - k);
            end
        end
    end
endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks a sampled Johnson counter, declares lock after LOCK_CNT clean +1 steps,
// and reports wraps and illegal codes/transitions.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int LOCK_CNT = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [JC_W-1:0]  jc_in,
    input  logic             jc_valid,
    input  logic             clr_err,
    output logic [PH_W-1:0]  phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);
    logic            dec_legal;
    logic [PH_W-1:0] dec_phase;

    johnson_decode u_dec (
        .jc_in (jc_in),
        .legal (dec_legal),
        .phase (dec_phase)
    );

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [PH_W-1:0] phase_d;
    logic            pv_d, locked_d, wrap_d, err_d;
    logic            step_inc, step_hold, step_done;

    // Step classification relative to the stored phase (mod-16 arithmetic).
    assign step_inc  = dec_legal && (dec_phase == phase + PH_W'(1));
    assign step_hold = dec_legal && (dec_phase == phase);
    assign step_done = ({1'b0, step_q} + 5'd1) == 5'(LOCK_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= UNLOCKED;
            step_q      <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            wrap        <= 1'b0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase       <= phase_d;
            phase_valid <= pv_d;
            locked      <= locked_d;
            wrap        <= wrap_d;
            err         <= err_d;
            // A same-cycle error survives the clear and counts as the first one.
            if (clr_err) begin
                err_sticky <= err_d;
                err_cnt    <= ERR_W'(err_d);
            end else if (err_d) begin
                err_sticky <= 1'b1;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (jc_valid) begin
            if (!dec_legal) begin
                state_d = UNLOCKED;
                step_d  = '0;
            end else if (state_q == UNLOCKED) begin
                state_d = LOCKING;
                step_d  = '0;
            end else if (step_inc) begin
                if (state_q == LOCKING) begin
                    step_d = step_q + 4'd1;
                    if (step_done)
                        state_d = LOCKED;
                end
            end else if (!step_hold) begin
                state_d = LOCKING;
                step_d  = '0;
            end
        end
    end

    // A jump to phase 0 is the counter's own reset: resync silently.
    always_comb begin
        phase_d  = phase;
        pv_d     = phase_valid;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        locked_d = (state_d == LOCKED);
        if (jc_valid) begin
            if (!dec_legal) begin
                pv_d  = 1'b0;
                err_d = 1'b1;
            end else begin
                phase_d = dec_phase;
                pv_d    = 1'b1;
                if (state_q != UNLOCKED) begin
                    wrap_d = step_inc && (phase == '1);
                    err_d  = !step_inc && !step_hold && (dec_phase != '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench: the driver queues hand-computed expectations, the monitor
// pops one per driven cycle and compares the registered outputs.
module tb_johnson_phase_monitor;
    typedef struct packed {
        logic [3:0] ph;
        logic       pv;
        logic       lk;
        logic       wr;
        logic       er;
        logic       st;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] jc_in = 8'h00;
    logic       jc_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] phase;
    logic       phase_valid, locked, wrap, err, err_sticky;
    logic [7:0] err_cnt;

    logic       issued = 1'b0;
    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         sample = 0;

    logic [7:0] codes [16] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                               8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    logic [7:0] bad [6] = '{8'hA5, 8'h5A, 8'h81, 8'h12, 8'h3C, 8'h77};

    johnson_phase_monitor #(.LOCK_CNT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .jc_in       (jc_in),
        .jc_valid    (jc_valid),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .locked      (locked),
        .wrap        (wrap),
        .err         (err),
        .err_sticky  (err_sticky),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int ph, input logic pv, input logic lk, input logic wr,
                                input logic er, input logic st, input int cnt);
        exp_t e;
        e.ph = 4'(ph); e.pv = pv; e.lk = lk; e.wr = wr; e.er = er; e.st = st; e.cnt = 8'(cnt);
        return e;
    endfunction

    function automatic exp_t cur();
        return mk(int'(phase), phase_valid, locked, wrap, err, err_sticky, int'(err_cnt));
    endfunction

    function automatic void show(input string name, input exp_t a, input exp_t e);
        $display("FAIL %s: got ph=%0d pv=%b lk=%b wr=%b er=%b st=%b cnt=%0d, want ph=%0d pv=%b lk=%b wr=%b er=%b st=%b cnt=%0d",
                 name, a.ph, a.pv, a.lk, a.wr, a.er, a.st, a.cnt, e.ph, e.pv, e.lk, e.wr, e.er, e.st, e.cnt);
    endfunction

    task automatic chk(input string name, input exp_t e);
        exp_t a;
        a = cur();
        checks++;
        if (a !== e) begin
            failures++;
            show(name, a, e);
        end
    endtask

    task automatic drive(input logic [7:0] jc, input logic v, input logic clr, input exp_t e);
        @(negedge clk);
        jc_in = jc; jc_valid = v; clr_err = clr; issued = 1'b1;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        jc_valid = 1'b0; clr_err = 1'b0; issued = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: %0d expectations still queued, want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: one expectation per driven cycle, compared just after the edge.
    initial forever begin
        @(posedge clk);
        if (issued) begin
            #1;
            sample++;
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_empty: sample %0d had no expectation, want one queued", sample);
            end else begin
                exp_t e, a;
                e = q.pop_front();
                a = cur();
                checks++;
                if (a !== e) begin
                    failures++;
                    show($sformatf("sample%0d", sample), a, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;

        // 20 consecutive +1 codes: lock after the 5th, wrap at the 15->0 step.
        for (int i = 0; i < 20; i++)
            drive(codes[i % 16], 1'b1, 1'b0, mk(i % 16, 1, i >= 4, i == 16, 0, 0, 0));
        // Unqualified garbage must be ignored.
        drive(8'hA5, 1'b0, 1'b0, mk(3, 1, 1, 0, 0, 0, 0));
        // Phase 3 -> 5: illegal step, then +1, then counter's reset to 0.
        drive(8'hF8, 1'b1, 1'b0, mk(5, 1, 0, 0, 1, 1, 1));
        drive(8'hFC, 1'b1, 1'b0, mk(6, 1, 0, 0, 0, 1, 1));
        drive(8'h00, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 1, 1));
        drive(8'h80, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 1, 1));
        drive(8'hC0, 1'b1, 1'b0, mk(2, 1, 0, 0, 0, 1, 1));
        drive(8'hE0, 1'b1, 1'b0, mk(3, 1, 0, 0, 0, 1, 1));
        drive(8'hF0, 1'b1, 1'b0, mk(4, 1, 1, 0, 0, 1, 1));
        drive(8'hF0, 1'b1, 1'b0, mk(4, 1, 1, 0, 0, 1, 1));
        // Illegal code while locked, then re-entry through LOCKING.
        drive(8'hA5, 1'b1, 1'b0, mk(4, 0, 0, 0, 1, 1, 2));
        drive(8'hF8, 1'b1, 1'b0, mk(5, 1, 0, 0, 0, 1, 2));
        drive(8'hFC, 1'b1, 1'b0, mk(6, 1, 0, 0, 0, 1, 2));
        drive(8'hFE, 1'b1, 1'b1, mk(7, 1, 0, 0, 0, 0, 0));
        // Saturation, then clear coinciding with an error.
        for (int i = 0; i < 300; i++)
            drive(bad[i % 6], 1'b1, 1'b0, mk(7, 0, 0, 0, 1, 1, (i + 1 > 255) ? 255 : i + 1));
        drive(8'h3C, 1'b1, 1'b1, mk(7, 0, 0, 0, 1, 1, 1));
        drive(8'h12, 1'b1, 1'b0, mk(7, 0, 0, 0, 1, 1, 2));
        // Relock for the asynchronous reset test.
        for (int i = 0; i < 5; i++)
            drive(codes[i], 1'b1, 1'b0, mk(i, 1, i == 4, 0, 0, 1, 2));
        idle();
        drain();

        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        drive(8'hFC, 1'b1, 1'b0, mk(6, 1, 0, 0, 0, 0, 0));
        drive(8'hFE, 1'b1, 1'b0, mk(7, 1, 0, 0, 0, 0, 0));
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
